// File: rtl/hilo_muldiv_engine_if.sv
// hilo_muldiv_engine_if
//   Request/result bundle between the E-stage pipeline and the HI/LO
//   multiply/divide engine.
//   start : request strobe (pipeline -> engine)
//   op    : operation code, 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo
//   a, b  : operands rs / rt (a is also the mthi/mtlo source)
//   busy  : operation in flight (engine -> pipeline, used for stalls)
//   hi,lo : architectural HI/LO registers (engine -> pipeline)
interface hilo_muldiv_engine_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, hi, lo);
    modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/hilo_muldiv_engine.sv
// hilo_muldiv_engine
//   Multi-cycle multiply/divide unit owning the MIPS HI/LO registers.
//   A mult/multu/div/divu request latches its operands, holds busy for a
//   fixed number of cycles and then commits the result to HI/LO.
//   mthi/mtlo write HI/LO directly in one edge and never raise busy.
//   Ports:
//     clk   : clock, all state changes on the rising edge
//     reset : asynchronous active-high reset, clears all state
//     bus   : slave side of hilo_muldiv_engine_if (start/op/a/b in,
//             busy/hi/lo out)
module hilo_muldiv_engine #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    hilo_muldiv_engine_if.slave     bus
);

    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq_s;
    logic [31:0] ur_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [63:0] result;
    logic        commit_en;

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Result is formed combinationally from the latched operands; only the
    // commit edge is observable.
    always_comb begin
        prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u = {32'd0, a_q} * {32'd0, b_q};

        // Signed divide on magnitudes so 0x80000000 / -1 wraps to
        // 0x80000000 with remainder 0 instead of hitting signed overflow.
        mag_a = a_q[31] ? (~a_q + 32'd1) : a_q;
        mag_b = b_q[31] ? (~b_q + 32'd1) : b_q;
        uq_s  = (mag_b == '0) ? '0 : mag_a / mag_b;
        ur_s  = (mag_b == '0) ? '0 : mag_a % mag_b;
        quo_s = (a_q[31] ^ b_q[31]) ? (~uq_s + 32'd1) : uq_s;
        rem_s = a_q[31] ? (~ur_s + 32'd1) : ur_s;

        quo_u = (b_q == '0) ? '0 : a_q / b_q;
        rem_u = (b_q == '0) ? '0 : a_q % b_q;

        result = '0;
        case (op_q)
            2'd0: result = prod_s;
            2'd1: result = prod_u;
            2'd2: result = {rem_s, quo_s};
            2'd3: result = {rem_u, quo_u};
            default: result = '0;
        endcase

        // Divide by zero leaves HI/LO untouched.
        commit_en = !(op_q[1] && (b_q == '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            busy_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                op_q   <= bus.op[1:0];
                                a_q    <= bus.a;
                                b_q    <= bus.b;
                                cnt    <= bus.op[1] ? DIV_N : MUL_N;
                                state  <= RUN;
                                busy_q <= 1'b1;
                            end
                            3'd4: hi_q <= bus.a;
                            3'd5: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // start is ignored for all ops while running.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        if (commit_en) begin
                            hi_q <= result[63:32];
                            lo_q <= result[31:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
